shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares the single combinational 16-bit barrel shifter between two requesters: requester 0 is the execute-stage ALU and requester 1 is the multi-cycle unit. Each requester sends an operand, count and op with a valid/ready handshake. The block grants one requester per cycle using round-robin. It drives the shifter inputs, registers the shifter result and returns it to the winning requester on a held valid/ready response channel. At most one response is outstanding at a time.

## Interface
- N, 16, data width of operand and result
- C, 4, count width; shift amounts are 0..2^C-1
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  requester k presents an operation
- req0_ready / req1_ready  out  1  requester k is granted this cycle (combinational)
- req0_in / req1_in  in  N  operand
- req0_cnt / req1_cnt  in  C  shift amount
- req0_op / req1_op  in  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical
- sh_in  out  N  to shifter operand
- sh_cnt  out  C  to shifter count
- sh_op  out  2  to shifter op, same encoding as reqk_op
- sh_out  in  N  from shifter result, combinational from sh_*
- rsp0_valid / rsp1_valid  out  1  result pending for requester k
- rsp0_ready / rsp1_ready  in  1  requester k accepts result
- rsp_data  out  N  registered result, shared by both response channels
- busy  out  1  a response is pending

## Operation
- State machine:
  - IDLE: no response pending.
  - HOLD: rsp_data is valid for owner k; rspk_valid=1 and the other rsp valid=0.
- Grant is allowed when the state is IDLE, or when the state is HOLD and the pending response is accepted this cycle (rsp_owner valid & ready).
- Arbitration when grant is allowed:
  - Only one reqk_valid: grant k.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- reqk_ready = grant_k; at most one is high. The transfer is reqk_valid & reqk_ready.
- Shifter drive:
  - While granted: sh_in/sh_cnt/sh_op = granted requester's fields.
  - Otherwise: all zero.
- On a transfer from k:
  - rsp_data <= sh_out, rsp_owner <= k, last_grant <= k.
  - State -> HOLD.
- No transfer and the response is accepted: state -> IDLE; rsp_data keeps its value.
- No transfer and the response is not accepted: HOLD persists; rsp_data and owner are stable.
- Requesters must hold valid and all fields stable until ready. The block never drops a request once valid is seen; it needs no request storage.
- busy = (state == HOLD).
- Width and arithmetic rules:
  - Count 0 passes the operand unchanged for every op.
  - Shifts fill with zeros.
  - Rotates wrap bits modulo N.
  - Only the C count bits are used.

## Timing
- Reset values:
  - state IDLE.
  - last_grant=1, so req0 wins the first contention.
  - rsp_data=0, rsp0_valid=rsp1_valid=0, busy=0.
  - reqk_ready follows the grant logic.
- Reset mid-HOLD: the pending response is discarded immediately (asynchronous reset); it is not replayed.
- Latency: request accepted at edge T, rspk_valid=1 from T (the cycle after acceptance) with correct rsp_data.
- Throughput: one operation per cycle when the owner's rsp_ready is tied high.
- Simultaneous response accept and new request: the accept and the new grant happen in the same cycle (no bubble).
- Backpressure: while HOLD is not accepted, req0_ready=req1_ready=0 and the sh_* outputs are zero.

## Test plan
- Single request:
  - Stimulus: req0 in=0x8001, cnt=1, op=00, rsp0_ready=1.
  - Response: req0_ready=1 in cycle 0; rsp0_valid=1 in cycle 1 with rsp_data=0x0003, rsp1_valid=0.
- Contention, both requests held valid, rsp ready high:
  - Stimulus: req0 in=0x00F0, cnt=4, op=01; req1 in=0x00F0, cnt=4, op=11.
  - Response: grants 0,1,0,1; responses 0x0F00 (owner 0) and 0x000F (owner 1) alternate every cycle.
- Backpressure:
  - Stimulus: rsp0_ready=0 for 3 cycles after a req0 transfer, with req1_valid=1.
  - Response: rsp0_valid and rsp_data stable, busy=1, req1_ready=0. In the cycle rsp0_ready=1, req1_ready=1; rsp1_valid appears the next cycle.
- Count boundaries:
  - 0x1234 with cnt=0, all four ops -> 0x1234.
  - 0x8000 cnt=15 op=11 -> 0x0001.
  - 0x0001 cnt=15 op=10 -> 0x0002.
  - 0xFFFF cnt=15 op=01 -> 0x8000.
- Reset during HOLD:
  - Stimulus: drop rst_n mid-cycle while rsp1_valid=1 and rsp1_ready=0.
  - Response: rsp1_valid=0, rsp_data=0, busy=0 without waiting for a clock edge. After release with both requests valid, req0 is granted first.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external 16-bit barrel shifter between the
// execute-stage ALU (requester 0) and the multi-cycle unit (requester 1).
module shift_arbiter #(
  parameter int unsigned N = 16,
  parameter int unsigned C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in,
  input  logic [C-1:0] req0_cnt,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in,
  input  logic [C-1:0] req1_cnt,
  input  logic [1:0]   req1_op,
  output logic [N-1:0] sh_in,
  output logic [C-1:0] sh_cnt,
  output logic [1:0]   sh_op,
  input  logic [N-1:0] sh_out,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_data,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state, state_next;
  logic       owner, owner_next;
  logic       last_grant, last_grant_next;
  logic       accept;
  logic       grant0, grant1;
  logic       xfer;

  // Arbitration, shifter drive and next-state decode
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;
    accept          = 1'b0;
    grant0          = 1'b0;
    grant1          = 1'b0;
    xfer            = 1'b0;
    sh_in           = '0;
    sh_cnt          = '0;
    sh_op           = 2'b00;

    if (state == HOLD) begin
      accept = owner ? rsp1_ready : rsp0_ready;
    end

    if ((state == IDLE) || accept) begin
      if (req0_valid && req1_valid) begin
        grant1 = (last_grant == 1'b0);
        grant0 = ~grant1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end

    xfer = grant0 | grant1;

    if (grant0) begin
      sh_in  = req0_in;
      sh_cnt = req0_cnt;
      sh_op  = req0_op;
    end else if (grant1) begin
      sh_in  = req1_in;
      sh_cnt = req1_cnt;
      sh_op  = req1_op;
    end

    if (xfer) begin
      state_next      = HOLD;
      owner_next      = grant1;
      last_grant_next = grant1;
    end else if (accept) begin
      state_next = IDLE;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // State, ownership and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
      if (xfer) begin
        rsp_data <= sh_out;
      end
      rsp0_valid <= (state_next == HOLD) && !owner_next;
      rsp1_valid <= (state_next == HOLD) && owner_next;
      busy       <= (state_next == HOLD);
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with a behavioural shifter
// closing the sh_* loop.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_cnt, req1_cnt;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [15:0] sh_out;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.N(16), .C(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in(req0_in), .req0_cnt(req0_cnt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in(req1_in), .req1_cnt(req1_cnt), .req1_op(req1_op),
    .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op), .sh_out(sh_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] c,
                                      input logic [1:0] op);
    logic [31:0] t;
    case (op)
      2'b00: begin t = {d, d} << c; shf = t[31:16]; end
      2'b01: shf = d << c;
      2'b10: begin t = {d, d} >> c; shf = t[15:0]; end
      default: shf = d >> c;
    endcase
  endfunction

  always_comb sh_out = shf(sh_in, sh_cnt, sh_op);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] c,
                      input logic [1:0] op);
    req0_valid = v; req0_in = d; req0_cnt = c; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] c,
                      input logic [1:0] op);
    req1_valid = v; req1_in = d; req1_cnt = c; req1_op = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  c;
    logic [1:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_n = 1'b0;
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    set1(1'b0, 16'h0, 4'h0, 2'b00);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #3;
    check("rst_rsp0_valid", 16'(rsp0_valid), 16'h0);
    check("rst_rsp1_valid", 16'(rsp1_valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_rsp_data", rsp_data, 16'h0);
    #9 rst_n = 1'b1;

    // Contention: grants alternate starting with requester 0
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 16'h00F0, 4'd4, 2'b01);
    set1(1'b1, 16'h00F0, 4'd4, 2'b11);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_ready0", 16'(req0_ready), 16'((i % 2) == 0));
      check("cont_ready1", 16'(req1_ready), 16'((i % 2) == 1));
      step();
      check("cont_rsp0_valid", 16'(rsp0_valid), 16'((i % 2) == 0));
      check("cont_rsp1_valid", 16'(rsp1_valid), 16'((i % 2) == 1));
      check("cont_data", rsp_data, ((i % 2) == 0) ? 16'h0F00 : 16'h000F);
    end
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    set1(1'b0, 16'h0, 4'h0, 2'b00);
    step();
    check("cont_drain_busy", 16'(busy), 16'h0);

    // Single request
    set0(1'b1, 16'h8001, 4'd1, 2'b00);
    #1;
    check("single_ready0", 16'(req0_ready), 16'h1);
    check("single_ready1", 16'(req1_ready), 16'h0);
    check("single_sh_in", sh_in, 16'h8001);
    step();
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    check("single_rsp0_valid", 16'(rsp0_valid), 16'h1);
    check("single_rsp1_valid", 16'(rsp1_valid), 16'h0);
    check("single_data", rsp_data, 16'h0003);
    check("single_busy", 16'(busy), 16'h1);
    step();
    check("single_idle", 16'(busy), 16'h0);

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    set0(1'b1, 16'hABCD, 4'd8, 2'b00);
    step();
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    set1(1'b1, 16'h0F0F, 4'd4, 2'b10);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp0_valid", 16'(rsp0_valid), 16'h1);
      check("bp_data", rsp_data, 16'hCDAB);
      check("bp_busy", 16'(busy), 16'h1);
      check("bp_ready1", 16'(req1_ready), 16'h0);
      check("bp_sh_in", sh_in, 16'h0);
      step();
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_ready1", 16'(req1_ready), 16'h1);
    step();
    set1(1'b0, 16'h0, 4'h0, 2'b00);
    check("bp_rsp1_valid", 16'(rsp1_valid), 16'h1);
    check("bp_rsp0_clear", 16'(rsp0_valid), 16'h0);
    check("bp_rsp1_data", rsp_data, 16'hF0F0);
    step();
    check("bp_idle", 16'(busy), 16'h0);

    // Count boundaries, streamed back-to-back through requester 0
    vecs[0] = '{16'h1234, 4'd0,  2'b00, 16'h1234};
    vecs[1] = '{16'h1234, 4'd0,  2'b01, 16'h1234};
    vecs[2] = '{16'h1234, 4'd0,  2'b10, 16'h1234};
    vecs[3] = '{16'h1234, 4'd0,  2'b11, 16'h1234};
    vecs[4] = '{16'h8000, 4'd15, 2'b11, 16'h0001};
    vecs[5] = '{16'h0001, 4'd15, 2'b10, 16'h0002};
    vecs[6] = '{16'hFFFF, 4'd15, 2'b01, 16'h8000};
    vecs[7] = '{16'h8001, 4'd4,  2'b10, 16'h1800};
    for (int i = 0; i < 8; i++) begin
      set0(1'b1, vecs[i].d, vecs[i].c, vecs[i].op);
      step();
      check($sformatf("cnt_vec%0d", i), rsp_data, vecs[i].exp);
      check($sformatf("cnt_valid%0d", i), 16'(rsp0_valid), 16'h1);
    end
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    step();

    // Asynchronous reset while requester 1 holds an unaccepted response
    rsp1_ready = 1'b0;
    set1(1'b1, 16'h00FF, 4'd4, 2'b01);
    step();
    set1(1'b0, 16'h0, 4'h0, 2'b00);
    check("hold_rsp1_valid", 16'(rsp1_valid), 16'h1);
    check("hold_data", rsp_data, 16'h0FF0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp1_valid", 16'(rsp1_valid), 16'h0);
    check("arst_data", rsp_data, 16'h0);
    check("arst_busy", 16'(busy), 16'h0);
    set0(1'b1, 16'h0001, 4'd3, 2'b01);
    set1(1'b1, 16'h0001, 4'd3, 2'b00);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_ready0", 16'(req0_ready), 16'h1);
    check("post_rst_ready1", 16'(req1_ready), 16'h0);
    step();
    check("post_rst_rsp0_valid", 16'(rsp0_valid), 16'h1);
    check("post_rst_data", rsp_data, 16'h0008);
    set0(1'b0, 16'h0, 4'h0, 2'b00);
    set1(1'b0, 16'h0, 4'h0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
